// File: rtl/qbert_pkg.sv
// Shared Q*bert geometry and type definitions.
// Imported by qbert_grid_pos and qbert_hop_ctrl. cube_generator reuses the geometry.
package qbert_pkg;

    typedef enum logic [1:0] {UL, UR, DL, DR} dir_t;
    typedef enum logic [1:0] {IDLE, HOP, LAND} hop_state_t;

    // Screen position of the pyramid apex (row 0, col 0)
    localparam logic [10:0] X_ORIGIN = 11'd400;
    localparam logic [9:0]  Y_ORIGIN = 10'd200;
    // One hop spans one cube diagonal
    localparam logic [10:0] STEP_X   = 11'd50;
    localparam logic [9:0]  STEP_Y   = 10'd90;

endpackage

// File: rtl/qbert_grid_pos.sv
// Combinational grid cell -> screen position mapping.
//   row, col : pyramid cell (row 0 is the apex)
//   x, y     : on-screen position of that cell
module qbert_grid_pos
    import qbert_pkg::*;
(
    input  logic [2:0]  row,
    input  logic [2:0]  col,
    output logic [10:0] x,
    output logic [9:0]  y
);

    // 13-bit two's-complement arithmetic; (2*col - row) may go negative
    always_comb begin
        x = 11'(13'(X_ORIGIN) + (13'({col, 1'b0}) - 13'(row)) * 13'(STEP_X));
        y = 10'(13'(Y_ORIGIN) + 13'(row) * 13'(STEP_Y));
    end

endmodule

// File: rtl/qbert_hop_ctrl.sv
// Q*bert hop controller: accepts UL/UR/DL/DR hop commands on the cube pyramid and
// animates the hop one video frame at a time (linear glide plus a vertical arc).
//   clk, reset           : clock, asynchronous active-low reset
//   frame_tick           : one-cycle pulse per video frame
//   move_valid/move_dir  : hop request; accepted when move_ready is high
//   move_ready           : high only while idle
//   move_reject          : one-cycle pulse when an accepted hop would leave the pyramid
//   landed               : one-cycle pulse when a hop completes
//   row, col             : committed grid cell
//   qbert_x, qbert_y     : current screen position for cube_generator
module qbert_hop_ctrl
    import qbert_pkg::*;
#(
    parameter int unsigned HOP_FRAMES = 10,
    parameter int unsigned LIFT       = 4,
    parameter int unsigned ROWS       = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        move_valid,
    input  logic [1:0]  move_dir,
    output logic        move_ready,
    output logic        move_reject,
    output logic        landed,
    output logic [2:0]  row,
    output logic [2:0]  col,
    output logic [10:0] qbert_x,
    output logic [9:0]  qbert_y
);

    localparam int unsigned KW      = $clog2(HOP_FRAMES + 1);
    localparam int unsigned DX_STEP = 32'(STEP_X) / HOP_FRAMES;
    localparam int unsigned DY_STEP = 32'(STEP_Y) / HOP_FRAMES;
    localparam logic signed [4:0] ROWS_S = 5'(ROWS);

    hop_state_t     state_q, state_d;
    dir_t           dir_q, dir_d;
    logic [KW-1:0]  k_q, k_d;
    logic [2:0]     row_q, row_d, col_q, col_d;
    logic [2:0]     tgt_row_q, tgt_row_d, tgt_col_q, tgt_col_d;
    logic [10:0]    start_x_q, start_x_d, x_q, x_d;
    logic [9:0]     start_y_q, start_y_d, y_q, y_d;
    logic           reject_q, reject_d;

    logic [10:0]    cur_x, tgt_x;
    logic [9:0]     cur_y, tgt_y;

    qbert_grid_pos u_cur_pos (
        .row (row_q),
        .col (col_q),
        .x   (cur_x),
        .y   (cur_y)
    );

    qbert_grid_pos u_tgt_pos (
        .row (tgt_row_q),
        .col (tgt_col_q),
        .x   (tgt_x),
        .y   (tgt_y)
    );

    // Candidate target cell for the request currently on move_dir
    dir_t              req_dir;
    logic signed [4:0] nxt_row, nxt_col;
    logic              req_legal;

    always_comb begin
        req_dir = dir_t'(move_dir);
        nxt_row = $signed({2'b00, row_q})
                + (((req_dir == DL) || (req_dir == DR)) ? 5'sd1 : -5'sd1);
        nxt_col = $signed({2'b00, col_q});
        if (req_dir == DR) nxt_col = nxt_col + 5'sd1;
        if (req_dir == UL) nxt_col = nxt_col - 5'sd1;
        req_legal = (nxt_row >= 5'sd0) && (nxt_row < ROWS_S)
                 && (nxt_col >= 5'sd0) && (nxt_col <= nxt_row);
    end

    // Animation position for the frame index after this tick
    logic [KW-1:0] k_inc, k_rem, arc_k;
    logic          go_right, go_down;
    logic [12:0]   dx_off, dy_off, arc;

    always_comb begin
        k_inc    = k_q + KW'(1);
        k_rem    = KW'(HOP_FRAMES) - k_inc;
        arc_k    = (k_inc < k_rem) ? k_inc : k_rem;
        go_right = (dir_q == UR) || (dir_q == DR);
        go_down  = (dir_q == DL) || (dir_q == DR);
        dx_off   = 13'(k_inc) * 13'(DX_STEP);
        dy_off   = 13'(k_inc) * 13'(DY_STEP);
        arc      = 13'(arc_k) * 13'(LIFT);
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        k_d       = k_q;
        row_d     = row_q;
        col_d     = col_q;
        tgt_row_d = tgt_row_q;
        tgt_col_d = tgt_col_q;
        start_x_d = start_x_q;
        start_y_d = start_y_q;
        x_d       = x_q;
        y_d       = y_q;
        reject_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // frame_tick is ignored here; the first advance comes from HOP
                if (move_valid) begin
                    if (req_legal) begin
                        dir_d     = req_dir;
                        tgt_row_d = nxt_row[2:0];
                        tgt_col_d = nxt_col[2:0];
                        start_x_d = cur_x;
                        start_y_d = cur_y;
                        k_d       = '0;
                        state_d   = HOP;
                    end else begin
                        reject_d  = 1'b1;
                    end
                end
            end
            HOP: begin
                if (frame_tick) begin
                    k_d = k_inc;
                    x_d = 11'(13'(start_x_q) + (go_right ? dx_off : -dx_off));
                    y_d = 10'(13'(start_y_q) + (go_down ? dy_off : -dy_off) - arc);
                    if (k_inc == KW'(HOP_FRAMES)) begin
                        // Snap to the exact target cell and commit it as landed
                        x_d     = tgt_x;
                        y_d     = tgt_y;
                        row_d   = tgt_row_q;
                        col_d   = tgt_col_q;
                        state_d = LAND;
                    end
                end
            end
            LAND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            dir_q     <= UL;
            k_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            tgt_row_q <= '0;
            tgt_col_q <= '0;
            start_x_q <= X_ORIGIN;
            start_y_q <= Y_ORIGIN;
            x_q       <= X_ORIGIN;
            y_q       <= Y_ORIGIN;
            reject_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            k_q       <= k_d;
            row_q     <= row_d;
            col_q     <= col_d;
            tgt_row_q <= tgt_row_d;
            tgt_col_q <= tgt_col_d;
            start_x_q <= start_x_d;
            start_y_q <= start_y_d;
            x_q       <= x_d;
            y_q       <= y_d;
            reject_q  <= reject_d;
        end
    end

    always_comb begin
        move_ready  = (state_q == IDLE);
        landed      = (state_q == LAND);
        move_reject = reject_q;
        row         = row_q;
        col         = col_q;
        qbert_x     = x_q;
        qbert_y     = y_q;
    end

endmodule

// File: tb/tb_qbert_hop_ctrl.sv
module tb_qbert_hop_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic        move_valid;
    logic [1:0]  move_dir;
    logic        move_ready;
    logic        move_reject;
    logic        landed;
    logic [2:0]  row;
    logic [2:0]  col;
    logic [10:0] qbert_x;
    logic [9:0]  qbert_y;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] D_UL = 2'd0;
    localparam logic [1:0] D_UR = 2'd1;
    localparam logic [1:0] D_DL = 2'd2;
    localparam logic [1:0] D_DR = 2'd3;

    qbert_hop_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .move_valid  (move_valid),
        .move_dir    (move_dir),
        .move_ready  (move_ready),
        .move_reject (move_reject),
        .landed      (landed),
        .row         (row),
        .col         (col),
        .qbert_x     (qbert_x),
        .qbert_y     (qbert_y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_pos(input string tag, input int x, input int y);
        check({tag, "_x"}, 32'(qbert_x), 32'(x));
        check({tag, "_y"}, 32'(qbert_y), 32'(y));
    endtask

    task automatic check_cell(input string tag, input int r, input int c);
        check({tag, "_row"}, 32'(row), 32'(r));
        check({tag, "_col"}, 32'(col), 32'(c));
    endtask

    // One frame: pulse frame_tick for a single cycle, return at the next negedge
    task automatic frame();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    // Full hop of 10 frames from an idle state, ending back in IDLE
    task automatic do_hop(input logic [1:0] d);
        move_valid = 1'b1;
        move_dir   = d;
        @(negedge clk);
        move_valid = 1'b0;
        repeat (10) frame();
        check("hop_landed", 32'(landed), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        reset      = 1'b0;
        frame_tick = 1'b0;
        move_valid = 1'b0;
        move_dir   = D_UL;

        // 1: reset state
        repeat (2) @(negedge clk);
        check_cell("rst", 0, 0);
        check_pos("rst", 400, 200);
        check("rst_ready", 32'(move_ready), 32'd1);
        check("rst_landed", 32'(landed), 32'd0);
        check("rst_reject", 32'(move_reject), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check_pos("post_rst", 400, 200);

        // 2: UL off the apex is rejected
        move_valid = 1'b1;
        move_dir   = D_UL;
        @(negedge clk);
        move_valid = 1'b0;
        check("ul_reject", 32'(move_reject), 32'd1);
        check("ul_ready", 32'(move_ready), 32'd1);
        check_pos("ul", 400, 200);
        check_cell("ul", 0, 0);
        @(negedge clk);
        check("ul_reject_end", 32'(move_reject), 32'd0);

        // 3 + 4: DR hop accepted together with a frame_tick (no advance that cycle);
        // a DL request is then held through the whole hop
        move_valid = 1'b1;
        move_dir   = D_DR;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        move_dir   = D_DL;
        check("dr_busy", 32'(move_ready), 32'd0);
        check_pos("dr_k0", 400, 200);
        for (int i = 1; i <= 10; i++) begin
            frame();
            if (i == 1) check_pos("dr_tick1", 405, 205);
            if (i == 5) begin
                check_pos("dr_tick5", 425, 225);
                @(negedge clk);
                check_pos("dr_tick5_hold", 425, 225);
            end
            if (i < 10) begin
                check("dr_mid_landed", 32'(landed), 32'd0);
                check("dr_mid_ready", 32'(move_ready), 32'd0);
            end
        end
        check_pos("dr_tick10", 450, 290);
        check("dr_landed", 32'(landed), 32'd1);
        check_cell("dr", 1, 1);
        @(negedge clk);
        check("dl_ready", 32'(move_ready), 32'd1);
        check("dl_landed_end", 32'(landed), 32'd0);
        @(negedge clk);
        move_valid = 1'b0;
        check("dl_busy", 32'(move_ready), 32'd0);
        repeat (10) frame();
        check("dl_landed", 32'(landed), 32'd1);
        check_pos("dl", 400, 380);
        check_cell("dl", 2, 1);
        @(negedge clk);

        // 5: walk down to the bottom row, then DL off the bottom is rejected
        repeat (4) do_hop(D_DL);
        check_cell("bottom", 6, 1);
        check_pos("bottom", 200, 740);
        move_valid = 1'b1;
        move_dir   = D_DL;
        @(negedge clk);
        move_valid = 1'b0;
        check("bot_reject", 32'(move_reject), 32'd1);
        check("bot_ready", 32'(move_ready), 32'd1);
        frame();
        check_pos("bot_hold", 200, 740);
        check_cell("bot_hold", 6, 1);

        // 6: asynchronous reset in the middle of a UR hop
        move_valid = 1'b1;
        move_dir   = D_UR;
        @(negedge clk);
        move_valid = 1'b0;
        repeat (4) frame();
        check_pos("ur_tick4", 220, 688);
        #2;
        reset = 1'b0;
        #1;
        check_pos("async_rst", 400, 200);
        check_cell("async_rst", 0, 0);
        check("async_rst_ready", 32'(move_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("after_rst_ready", 32'(move_ready), 32'd1);
        check("after_rst_landed", 32'(landed), 32'd0);
        frame();
        check_pos("after_rst_tick", 400, 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
